// File: rtl/vga_pkg.sv
// vga_pkg: shared types and constants for the VGA stripe sequencer.
//   phase_t  - per-axis raster phase (ACT, FP, SYNC, BP)
//   mode_t   - pattern request codes
//   DEF_*    - default 640x480@60 timing constants
//   seg_total - total length of an axis from its four segment lengths
package vga_pkg;

  typedef enum logic [1:0] {
    PH_ACT  = 2'd0,
    PH_FP   = 2'd1,
    PH_SYNC = 2'd2,
    PH_BP   = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    MODE_VSTRIPE = 2'd0,
    MODE_HSTRIPE = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_BLANK   = 2'd3
  } mode_t;

  localparam int CNT_W = 16;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_STRIPE   = 80;

  function automatic int seg_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical).
//   clkin  - pixel clock
//   rst    - asynchronous active-high reset
//   step   - advance the axis by one position
//   count  - current position, 0..TOTAL-1
//   phase  - current phase (ACT/FP/SYNC/BP), always consistent with count
//   stripe - low three bits of count / STRIPE, restarting at the active start
//   wrap   - count is at TOTAL-1 (the next step returns to 0)
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter int STRIPE = DEF_STRIPE
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             step,
  output logic [CNT_W-1:0] count,
  output phase_t           phase,
  output logic [2:0]       stripe,
  output logic             wrap
);

  localparam int TOTAL = seg_total(ACTIVE, FP, SYNC, BP);

  localparam logic [CNT_W-1:0] LAST_ACT    = CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] LAST_FP     = CNT_W'(ACTIVE + FP - 1);
  localparam logic [CNT_W-1:0] LAST_SYNC   = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] LAST_ALL    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] LAST_STRIPE = CNT_W'(STRIPE - 1);

  phase_t           phase_next;
  logic [CNT_W-1:0] stripe_pos;

  // State register: position, phase and stripe counters advance together.
  // Only the low three stripe-index bits reach the colour logic, so the
  // index counter simply wraps modulo 8.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      count      <= '0;
      phase      <= PH_ACT;
      stripe_pos <= '0;
      stripe     <= '0;
    end else if (step) begin
      count <= wrap ? '0 : count + 1'b1;
      phase <= phase_next;
      if (wrap) begin
        stripe_pos <= '0;
        stripe     <= '0;
      end else if (stripe_pos == LAST_STRIPE) begin
        stripe_pos <= '0;
        stripe     <= stripe + 1'b1;
      end else begin
        stripe_pos <= stripe_pos + 1'b1;
      end
    end
  end

  // Next-state: leave a phase on the last position of its segment.
  always_comb begin
    phase_next = phase;
    case (phase)
      PH_ACT:  if (count == LAST_ACT)  phase_next = PH_FP;
      PH_FP:   if (count == LAST_FP)   phase_next = PH_SYNC;
      PH_SYNC: if (count == LAST_SYNC) phase_next = PH_BP;
      PH_BP:   if (count == LAST_ALL)  phase_next = PH_ACT;
      default: phase_next = PH_ACT;
    endcase
  end

  // Outputs
  always_comb begin
    wrap = (count == LAST_ALL);
  end

endmodule

// File: rtl/vga_stripe_sequencer.sv
// vga_stripe_sequencer: VGA raster timing plus stripe pattern generator.
//   clkin  - pixel clock, all state on rising edge
//   rst    - asynchronous active-high reset
//   en     - advance raster; 0 freezes all state and outputs
//   mode   - pattern request, sampled once per frame at the frame wrap
//   hout   - horizontal sync, active low
//   vout   - vertical sync, active low
//   rout/gout/bout - colour bits, forced to 0 outside active video
//   aout   - active video flag
//   hcsout - horizontal count of the pixel currently on the outputs
//   fsout  - high with the first pixel (0,0) of each frame
module vga_stripe_sequencer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int STRIPE   = DEF_STRIPE
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic             hout,
  output logic             vout,
  output logic             rout,
  output logic             gout,
  output logic             bout,
  output logic             aout,
  output logic [CNT_W-1:0] hcsout,
  output logic             fsout
);

  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  phase_t           hphase;
  phase_t           vphase;
  logic [2:0]       sx;
  logic [2:0]       sy;
  logic             h_wrap;
  logic             v_wrap;
  logic             v_step;
  logic             frame_wrap;
  mode_t            mode_q;
  logic             active;
  logic [2:0]       colour;

  assign v_step     = en & h_wrap;
  assign frame_wrap = en & h_wrap & v_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .STRIPE (STRIPE)
  ) u_h_axis (
    .clkin  (clkin),
    .rst    (rst),
    .step   (en),
    .count  (hcnt),
    .phase  (hphase),
    .stripe (sx),
    .wrap   (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .STRIPE (STRIPE)
  ) u_v_axis (
    .clkin  (clkin),
    .rst    (rst),
    .step   (v_step),
    .count  (vcnt),
    .phase  (vphase),
    .stripe (sy),
    .wrap   (v_wrap)
  );

  // The pattern only changes on the frame boundary so a frame is never torn.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_VSTRIPE;
    end else if (frame_wrap) begin
      mode_q <= mode_t'(mode);
    end
  end

  always_comb begin
    active = (hphase == PH_ACT) && (vphase == PH_ACT);
    colour = 3'b000;
    if (active) begin
      case (mode_q)
        MODE_VSTRIPE: colour = sx;
        MODE_HSTRIPE: colour = sy;
        MODE_CHECKER: colour = {3{sx[0] ^ sy[0]}};
        default:      colour = 3'b000;
      endcase
    end
  end

  // Output register: everything describing one pixel, including its
  // horizontal position, is captured on the same edge.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      hout   <= 1'b1;
      vout   <= 1'b1;
      rout   <= 1'b0;
      gout   <= 1'b0;
      bout   <= 1'b0;
      aout   <= 1'b0;
      hcsout <= '0;
      fsout  <= 1'b0;
    end else if (en) begin
      hout                <= (hphase != PH_SYNC);
      vout                <= (vphase != PH_SYNC);
      {rout, gout, bout}  <= colour;
      aout                <= active;
      hcsout              <= hcnt;
      fsout               <= (hcnt == '0) && (vcnt == '0);
    end
  end

endmodule

// File: tb/tb_vga_stripe_sequencer.sv
// Testbench for vga_stripe_sequencer using a reduced raster
// (32 pixels x 14 lines, stripe width 3) so whole frames fit in a short run.
module tb_vga_stripe_sequencer;

  localparam int HA = 24, HF = 2, HS = 3, HB = 3;
  localparam int VA = 9,  VF = 1, VS = 2, VB = 2;
  localparam int ST = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clkin = 1'b0;
  logic        rst   = 1'b1;
  logic        en    = 1'b0;
  logic [1:0]  mode  = 2'd0;
  logic        hout, vout, rout, gout, bout, aout, fsout;
  logic [15:0] hcsout;

  int tests = 0;
  int fails = 0;

  // Bench-side raster model: position of the next pixel and latched mode.
  int          mh = 0;
  int          mv = 0;
  logic [1:0]  mq = 2'd0;
  int          exp_h = 0;
  int          exp_v = 0;
  logic [22:0] exp_vec = '0;

  wire [22:0] obs = {hout, vout, rout, gout, bout, aout, fsout, hcsout};

  always #5 clkin = ~clkin;

  vga_stripe_sequencer #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .STRIPE   (ST)
  ) dut (
    .clkin  (clkin),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .hout   (hout),
    .vout   (vout),
    .rout   (rout),
    .gout   (gout),
    .bout   (bout),
    .aout   (aout),
    .hcsout (hcsout),
    .fsout  (fsout)
  );

  // Expected output word {hs, vs, rgb, a, fs, h} for pixel (h, v) in mode m.
  function automatic logic [22:0] ref_out(input int h, input int v, input logic [1:0] m);
    logic       a, hs, vs, fs;
    logic [2:0] c;
    int         sx, sy;
    a  = (h < HA) && (v < VA);
    hs = !((h >= HA + HF) && (h < HA + HF + HS));
    vs = !((v >= VA + VF) && (v < VA + VF + VS));
    sx = h / ST;
    sy = v / ST;
    case (m)
      2'd0:    c = 3'(sx % 8);
      2'd1:    c = 3'(sy % 8);
      2'd2:    c = (((sx ^ sy) & 1) != 0) ? 3'b111 : 3'b000;
      default: c = 3'b000;
    endcase
    if (!a) c = 3'b000;
    fs = (h == 0) && (v == 0);
    return {hs, vs, c, a, fs, 16'(h)};
  endfunction

  // One clock: update the model for the edge, then return at the falling edge.
  task automatic advance();
    @(posedge clkin);
    if (en) begin
      exp_vec = ref_out(mh, mv, mq);
      exp_h   = mh;
      exp_v   = mv;
      if (mh == HT - 1 && mv == VT - 1) mq = mode;
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
    @(negedge clkin);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 2'd0;
    repeat (3) @(negedge clkin);
    tests++; if (hout !== 1'b1)  begin fails++; $display("FAIL reset_hout: got %b want 1", hout); end
    tests++; if (vout !== 1'b1)  begin fails++; $display("FAIL reset_vout: got %b want 1", vout); end
    tests++; if ({rout, gout, bout} !== 3'b000) begin fails++; $display("FAIL reset_rgb: got %b want 000", {rout, gout, bout}); end
    tests++; if (aout !== 1'b0)  begin fails++; $display("FAIL reset_aout: got %b want 0", aout); end
    tests++; if (hcsout !== 16'd0) begin fails++; $display("FAIL reset_hcs: got %0d want 0", hcsout); end
    tests++; if (fsout !== 1'b0) begin fails++; $display("FAIL reset_fs: got %b want 0", fsout); end
    mh = 0; mv = 0; mq = 2'd0;
    $display("[TB] reset: outputs checked");
  endtask

  task automatic test_first_pixel();
    rst = 1'b0;
    advance();
    tests++; if (fsout !== 1'b1)  begin fails++; $display("FAIL first_fs: got %b want 1", fsout); end
    tests++; if (hcsout !== 16'd0) begin fails++; $display("FAIL first_hcs: got %0d want 0", hcsout); end
    tests++; if (aout !== 1'b1)   begin fails++; $display("FAIL first_aout: got %b want 1", aout); end
    tests++; if ({rout, gout, bout} !== 3'b000) begin fails++; $display("FAIL first_rgb: got %b want 000", {rout, gout, bout}); end
    for (int i = 1; i < HT; i++) begin
      advance();
      tests++;
      if (obs !== exp_vec) begin fails++; $display("FAIL line0 h=%0d: got %h want %h", exp_h, obs, exp_vec); end
      if (i == ST) begin
        tests++; if ({rout, gout, bout} !== 3'b001) begin fails++; $display("FAIL stripe1_rgb: got %b want 001", {rout, gout, bout}); end
      end
      if (i == HA) begin
        tests++; if (aout !== 1'b0) begin fails++; $display("FAIL aout_fall: got %b want 0", aout); end
      end
    end
    $display("[TB] first line: pixel (0,0) and line 0 checked");
  endtask

  task automatic test_free_frame();
    int fs_first = -1, fs_second = -1, hlow = 0, hfirst = -1, vlow = 0;
    int base = (VT - 1) * HT;
    for (int k = 0; k < base + FRAME + 1; k++) begin
      advance();
      tests++;
      if (obs !== exp_vec) begin fails++; $display("FAIL frame_px h=%0d v=%0d: got %h want %h", exp_h, exp_v, obs, exp_vec); end
      if (fsout === 1'b1) begin
        if (fs_first < 0) fs_first = k;
        else if (fs_second < 0) fs_second = k;
      end
      if (k >= base && k < base + HT && hout === 1'b0) begin
        hlow++;
        if (hfirst < 0) hfirst = int'(hcsout);
      end
      if (k >= base && k < base + FRAME && vout === 1'b0) vlow++;
    end
    tests++; if (hlow != HS) begin fails++; $display("FAIL hsync_width: got %0d want %0d", hlow, HS); end
    tests++; if (hfirst != HA + HF) begin fails++; $display("FAIL hsync_start: got %0d want %0d", hfirst, HA + HF); end
    tests++; if (vlow != VS * HT) begin fails++; $display("FAIL vsync_width: got %0d want %0d", vlow, VS * HT); end
    tests++; if (fs_first != base) begin fails++; $display("FAIL fs_first: got %0d want %0d", fs_first, base); end
    tests++; if (fs_second - fs_first != FRAME) begin fails++; $display("FAIL fs_period: got %0d want %0d", fs_second - fs_first, FRAME); end
    $display("[TB] free run: sync widths and frame period checked");
  endtask

  task automatic test_mode_midframe();
    int guard = 0;
    repeat (100) begin
      advance();
      tests++; if (obs !== exp_vec) begin fails++; $display("FAIL pre_mode h=%0d v=%0d: got %h want %h", exp_h, exp_v, obs, exp_vec); end
    end
    mode = 2'd1;
    while (!(mh == 0 && mv == 0) && guard < 2 * FRAME) begin
      advance(); guard++;
      tests++; if (obs !== exp_vec) begin fails++; $display("FAIL mode_wait h=%0d v=%0d: got %h want %h", exp_h, exp_v, obs, exp_vec); end
    end
    tests++; if (guard >= 2 * FRAME) begin fails++; $display("FAIL mode_wait_timeout: got %0d want <%0d", guard, 2 * FRAME); end
    for (int k = 0; k < FRAME; k++) begin
      advance();
      tests++; if (obs !== exp_vec) begin fails++; $display("FAIL hstripe h=%0d v=%0d: got %h want %h", exp_h, exp_v, obs, exp_vec); end
      if (k == 5) begin
        tests++; if ({rout, gout, bout} !== 3'b000) begin fails++; $display("FAIL hstripe_row0: got %b want 000", {rout, gout, bout}); end
      end
      if (k == 3 * HT + 5) begin
        tests++; if ({rout, gout, bout} !== 3'b001) begin fails++; $display("FAIL hstripe_row3: got %b want 001", {rout, gout, bout}); end
      end
    end
    $display("[TB] mode 1 mid-frame request checked");
  endtask

  task automatic test_simultaneous_wrap();
    int guard = 0;
    int lit = 0;
    while (!(mh == HT - 1 && mv == VT - 1) && guard < 2 * FRAME) begin
      advance(); guard++;
      tests++; if (obs !== exp_vec) begin fails++; $display("FAIL wrap_wait h=%0d v=%0d: got %h want %h", exp_h, exp_v, obs, exp_vec); end
    end
    tests++; if (guard >= 2 * FRAME) begin fails++; $display("FAIL wrap_wait_timeout: got %0d want <%0d", guard, 2 * FRAME); end
    mode = 2'd2;
    for (int k = 0; k < FRAME + 1; k++) begin
      advance();
      tests++; if (obs !== exp_vec) begin fails++; $display("FAIL checker h=%0d v=%0d: got %h want %h", exp_h, exp_v, obs, exp_vec); end
      if (k == 4) begin
        tests++; if ({rout, gout, bout} !== 3'b111) begin fails++; $display("FAIL checker_3_0: got %b want 111", {rout, gout, bout}); end
      end
      if (k == 1 + 3 * HT + 3) begin
        tests++; if ({rout, gout, bout} !== 3'b000) begin fails++; $display("FAIL checker_3_3: got %b want 000", {rout, gout, bout}); end
      end
    end
    mode = 2'd3;
    for (int k = 0; k < 2 * FRAME; k++) begin
      advance();
      tests++; if (obs !== exp_vec) begin fails++; $display("FAIL blank h=%0d v=%0d: got %h want %h", exp_h, exp_v, obs, exp_vec); end
      if (k >= FRAME && {rout, gout, bout} !== 3'b000) lit++;
    end
    tests++; if (lit != 0) begin fails++; $display("FAIL blank_lit: got %0d want 0", lit); end
    $display("[TB] mode change at frame wrap and blank mode checked");
  endtask

  task automatic test_enable_hold();
    int period = 0;
    mode = 2'd0;
    advance();
    tests++; if (fsout !== 1'b1) begin fails++; $display("FAIL hold_fs_start: got %b want 1", fsout); end
    repeat (2 * HT + 10) begin
      advance(); period++;
      tests++; if (obs !== exp_vec) begin fails++; $display("FAIL hold_pre h=%0d v=%0d: got %h want %h", exp_h, exp_v, obs, exp_vec); end
    end
    en = 1'b0;
    repeat (37) begin
      advance(); period++;
      tests++; if (obs !== exp_vec) begin fails++; $display("FAIL hold_frozen h=%0d v=%0d: got %h want %h", exp_h, exp_v, obs, exp_vec); end
    end
    en = 1'b1;
    do begin
      advance(); period++;
      tests++; if (obs !== exp_vec) begin fails++; $display("FAIL hold_post h=%0d v=%0d: got %h want %h", exp_h, exp_v, obs, exp_vec); end
    end while (fsout !== 1'b1 && period < 2 * FRAME);
    tests++; if (period != FRAME + 37) begin fails++; $display("FAIL hold_period: got %0d want %0d", period, FRAME + 37); end
    en = 1'b0;
    repeat (3) begin
      advance();
      tests++; if (fsout !== 1'b1) begin fails++; $display("FAIL hold_fs_frozen: got %b want 1", fsout); end
    end
    en = 1'b1;
    $display("[TB] enable hold: frozen outputs and stretched frame checked");
  endtask

  task automatic test_async_reset();
    int guard = 0;
    while (!(mh == 5 && mv == VA + VF) && guard < 2 * FRAME) begin
      advance(); guard++;
      tests++; if (obs !== exp_vec) begin fails++; $display("FAIL rst_wait h=%0d v=%0d: got %h want %h", exp_h, exp_v, obs, exp_vec); end
    end
    tests++; if (vout !== 1'b0) begin fails++; $display("FAIL rst_pre_vsync: got %b want 0", vout); end
    #2;
    rst = 1'b1;
    mode = 2'd2;
    #1;
    tests++; if (vout !== 1'b1)   begin fails++; $display("FAIL rst_async_vout: got %b want 1", vout); end
    tests++; if (hout !== 1'b1)   begin fails++; $display("FAIL rst_async_hout: got %b want 1", hout); end
    tests++; if (aout !== 1'b0)   begin fails++; $display("FAIL rst_async_aout: got %b want 0", aout); end
    tests++; if (hcsout !== 16'd0) begin fails++; $display("FAIL rst_async_hcs: got %0d want 0", hcsout); end
    tests++; if (fsout !== 1'b0)  begin fails++; $display("FAIL rst_async_fs: got %b want 0", fsout); end
    @(negedge clkin);
    @(negedge clkin);
    rst = 1'b0;
    mh = 0; mv = 0; mq = 2'd0;
    for (int k = 0; k < FRAME; k++) begin
      advance();
      tests++; if (obs !== exp_vec) begin fails++; $display("FAIL rst_recover h=%0d v=%0d: got %h want %h", exp_h, exp_v, obs, exp_vec); end
      if (k == 0) begin
        tests++; if (fsout !== 1'b1 || hcsout !== 16'd0) begin fails++; $display("FAIL rst_first_px: got fs=%b h=%0d want fs=1 h=0", fsout, hcsout); end
      end
      if (k == 3) begin
        tests++; if ({rout, gout, bout} !== 3'b001) begin fails++; $display("FAIL rst_mode0: got %b want 001", {rout, gout, bout}); end
      end
    end
    $display("[TB] asynchronous reset in vertical sync checked");
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_free_frame();
    test_mode_midframe();
    test_simultaneous_wrap();
    test_enable_hold();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_stripe_sequencer.md
# vga_stripe_sequencer

Timing and pattern controller for the VGA stripes display path: it drives the raster, sync and colour outputs consumed at the top level (`hout`, `vout`, `rout`, `gout`, `bout`, `aout`, `hcsout`). It contains a horizontal and a vertical phase state machine (active, front porch, sync, back porch). A pattern scheduler selects a stripe mode once per frame and gates colour to the active region. It sits directly behind the pixel clock input and replaces free-running counter logic in `top`.

## Interface
- `H_ACTIVE`, 640: active pixels per line
- `H_FP`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: horizontal sync width, pixels
- `H_BP`, 48: horizontal back porch, pixels
- `V_ACTIVE`, 480: active lines per frame
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vertical sync width, lines
- `V_BP`, 33: vertical back porch, lines
- `STRIPE`, 80: stripe width in pixels or lines; power of two not required
- `clkin`  in  1  pixel clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  advance raster; 0 freezes counters, phases and outputs
- `mode`  in  2  pattern request: 0 vertical stripes, 1 horizontal stripes, 2 checker, 3 blank
- `hout`  out  1  horizontal sync, active low
- `vout`  out  1  vertical sync, active low
- `rout`, `gout`, `bout`  out  1 each  colour bits
- `aout`  out  1  active-video flag
- `hcsout`  out  16  horizontal count that produced the current outputs
- `fsout`  out  1  one-cycle pulse with the first output of each frame (hcsout=0, line 0)

## Operation
- `H_TOTAL` = 800 and `V_TOTAL` = 525 with the default parameters. Each total is the sum of its four segments.
- `hcnt` counts 0..H_TOTAL-1 with wrap. `vcnt` increments only when `hcnt` wraps, and wraps at V_TOTAL-1.
- Line order is ACT [0, H_ACTIVE), FP, SYNC [H_ACTIVE+H_FP, +H_SYNC), BP. Default SYNC spans 656..751.
- Frame order is the same scheme in lines. Default vertical SYNC spans lines 490..491.
- Each axis has a 2-bit phase FSM: ACT→FP→SYNC→BP→ACT. A transition occurs when the segment's local count reaches segment length-1 with `en`=1. FSM state and counter must always agree.
- `mode` is sampled into `mode_q` only at the frame wrap, when hcnt=H_TOTAL-1, vcnt=V_TOTAL-1 and en=1. A mid-frame change has no effect until the next frame.
- Stripe indices: `sx` = hcnt / STRIPE, `sy` = vcnt / STRIPE. Implement them with per-axis stripe counters, not dividers. Each stripe counter resets at the start of the active region.
- Colour {r,g,b}:
  - mode 0: sx[2:0]
  - mode 1: sy[2:0]
  - mode 2: {3{sx[0]^sy[0]}}
  - mode 3: 0
- Colour is forced to 0 whenever `aout`=0.
- `aout` = hphase==ACT && vphase==ACT. `hout` is low iff hphase==SYNC. `vout` is low iff vphase==SYNC.
- `en`=0 holds every register, including `fsout`. A held `fsout` pulse reasserts each frozen cycle.
- Arithmetic: counters are 16 bits wide. `hcsout` is zero-extended `hcnt`. Parameter totals must be < 65536.

## Timing
- All outputs are registered, with 1-cycle latency from counter state to pins. `hcsout` is registered alongside, so it always labels the pixel currently on the outputs.
- Reset values while `rst`=1:
  - hcnt=0, vcnt=0, both phases ACT, `mode_q`=0
  - outputs: `hout`=1, `vout`=1, rgb=0, `aout`=0, `hcsout`=0, `fsout`=0
- The first edge after reset release (en=1) presents pixel (0,0): `aout`=1, `fsout`=1, rgb=000 in mode 0.
- A reset asserted mid-line or mid-frame clears state immediately, without waiting for a clock edge. Recovery restarts at (0,0), with no partial sync pulse emitted beyond the reset point.
- Simultaneous frame wrap and `mode` change: the new mode is captured and applies to pixel (0,0) of the new frame.

## Structure
- Package `vga_pkg` holds:
  - the phase encoding: ACT=0, FP=1, SYNC=2, BP=3
  - mode codes
  - default 640x480 timing constants
- Sub-module `vga_axis_counter` (parameters: ACTIVE, FP, SYNC, BP, STRIPE) is instantiated twice:
  - inputs: `clkin`, `rst`, `step`
  - outputs: count, phase, stripe index, wrap
  - horizontal instance: step=en; vertical instance: step=en & h-wrap.

## Test plan
- Reset release with en=1, mode=0 → `fsout`=1 with `hcsout`=0; rgb steps 000,001,…,111 every 80 cycles; `aout` falls when `hcsout`=640.
- Free-run one line → `hout` low exactly 96 cycles, first low with `hcsout`=656; line period 800 cycles.
- Free-run one frame → `vout` low for lines 490–491 (1600 cycles); `fsout` period 420000 cycles.
- mode=1 asserted mid-frame → no colour change until the next `fsout`; afterwards colour is constant along each line and steps every 80 lines.
- en=0 for 37 cycles mid-line → all outputs frozen; raster resumes at the same `hcsout`; frame period extends by 37.
- rst pulse during vertical sync → `vout`=1 immediately (asynchronous); the next frame starts at (0,0) with `mode_q`=0.
